program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 185 ++++++++++++++++++
 tb/tb_program_loader.sv | 508 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Program loader: streams a program into instruction RAM, runs the CPU
// until it halts, lets the pipeline drain, then streams data memory out.
// Ports: i_clk, i_rst_n (sync, active-low); i_in_valid/o_in_ready,
//   i_in_data/i_in_last (program stream); o_imem_we/o_imem_addr/
//   o_imem_wdata (imem write); o_cpu_rst, i_cpu_stop (CPU control);
//   o_dmem_addr/i_dmem_rdata (dmem read); o_out_valid/i_out_ready,
//   o_out_data/o_out_last (dump stream); o_busy/o_done/o_err (status).
// Optional macro LOADER_TIMEOUT_EN adds a watchdog on the RUN state.
module program_loader #(
  parameter int IMEM_WORDS     = 512,
  parameter int DUMP_WORDS     = 512,
  parameter int DRAIN_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [31:0] i_in_data,
  input  logic        i_in_last,
  output logic        o_imem_we,
  output logic [31:0] o_imem_addr,
  output logic [31:0] o_imem_wdata,
  output logic        o_cpu_rst,
  input  logic        i_cpu_stop,
  output logic [31:0] o_dmem_addr,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [31:0] o_out_data,
  output logic        o_out_last,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam int WW = $clog2(IMEM_WORDS) + 1;
  localparam int RW = $clog2(DUMP_WORDS) + 1;
  localparam int DW = $clog2(DRAIN_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_DUMP,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WW-1:0] r_wr_cnt;
  logic [RW-1:0] r_rd_cnt;
  logic [DW-1:0] r_drain_cnt;
  logic          r_err;

  logic w_acc;
  logic w_hs;
  logic w_set_err;
  logic w_wr_full;
  logic w_rd_last;
  logic w_drain_end;
  logic w_tmo_hit;

  // Counters hold word indices; the bus addresses are byte addresses.
  assign o_imem_addr  = 32'(r_wr_cnt) << 2;
  assign o_imem_wdata = i_in_data;
  assign o_dmem_addr  = 32'(r_rd_cnt) << 2;
  assign o_out_data   = i_dmem_rdata;
  assign o_err        = r_err;

  assign w_wr_full   = (r_wr_cnt == WW'(IMEM_WORDS - 1));
  assign w_rd_last   = (r_rd_cnt == RW'(DUMP_WORDS - 1));
  assign w_drain_end = (r_drain_cnt == DW'(DRAIN_CYCLES - 1));

`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TW-1:0] r_tmo_cnt;

  assign w_tmo_hit = (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_tmo_cnt <= r_tmo_cnt + TW'(1);
    end else begin
      r_tmo_cnt <= '0;
    end
  end
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_comb begin
    w_next      = r_state;
    w_acc       = 1'b0;
    w_hs        = 1'b0;
    w_set_err   = 1'b0;
    o_in_ready  = 1'b0;
    o_imem_we   = 1'b0;
    o_cpu_rst   = 1'b1;
    o_out_valid = 1'b0;
    o_out_last  = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    unique case (r_state)
      S_LOAD: begin
        o_in_ready = 1'b1;
        w_acc      = i_in_valid;
        o_imem_we  = w_acc;
        if (w_acc) begin
          // in_last wins: a full program that is properly
          // terminated is not an overflow.
          if (i_in_last) begin
            w_next = S_RUN;
          end else if (w_wr_full) begin
            w_set_err = 1'b1;
            w_next    = S_RUN;
          end
        end
      end
      S_RUN: begin
        o_cpu_rst = 1'b0;
        if (i_cpu_stop) begin
          w_next = S_DRAIN;
        end else if (w_tmo_hit) begin
          w_set_err = 1'b1;
          w_next    = S_DRAIN;
        end
      end
      S_DRAIN: begin
        o_cpu_rst = 1'b0;
        if (w_drain_end) begin
          w_next = S_DUMP;
        end
      end
      S_DUMP: begin
        o_out_valid = 1'b1;
        o_out_last  = w_rd_last;
        w_hs        = i_out_ready;
        if (w_hs && w_rd_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        o_busy = 1'b0;
        o_done = 1'b1;
      end
      default: begin
        w_next = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_LOAD;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_drain_cnt <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_wr_cnt <= r_wr_cnt + WW'(1);
      end
      // rd_cnt stays put while the consumer stalls, which keeps
      // dmem_addr and therefore out_data stable.
      if (w_hs) begin
        r_rd_cnt <= r_rd_cnt + RW'(1);
      end
      if (r_state == S_DRAIN) begin
        r_drain_cnt <= r_drain_cnt + DW'(1);
      end else begin
        r_drain_cnt <= '0;
      end
      if (w_set_err) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Testbench for program_loader: randomized load/run/dump flows
// compared against a behavioural model of the loader's contract.
module tb_program_loader;

  localparam int IMW = 4;
  localparam int DMW = 4;
  localparam int DRN = 4;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        cpu_stop = 1'b0;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_rdata;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        err;

  logic [31:0] key = 32'hA5A5A5A5;
  logic [31:0] wbuf [8];
  logic [31:0] aq [$];
  logic [31:0] dq [$];

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Data memory model: each word is its byte address XOR a key.
  assign dmem_rdata = dmem_addr ^ key;

  program_loader #(
    .IMEM_WORDS    (IMW),
    .DUMP_WORDS    (DMW),
    .DRAIN_CYCLES  (DRN),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (in_data),
    .i_in_last   (in_last),
    .o_imem_we   (imem_we),
    .o_imem_addr (imem_addr),
    .o_imem_wdata(imem_wdata),
    .o_cpu_rst   (cpu_rst),
    .i_cpu_stop  (cpu_stop),
    .o_dmem_addr (dmem_addr),
    .i_dmem_rdata(dmem_rdata),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_out_last  (out_last),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time limit hit");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    cpu_stop = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // Offers n words from wbuf; gap 0 = back-to-back, 1 = 3 idle
  // cycles after each accepted word, 2 = random idle cycles.
  task automatic drive_load(
    input  int n,
    input  bit with_last,
    input  int gap,
    output int acc,
    output bit we_ok,
    output bit stalled
  );
    int idx = 0;
    int idle = 0;
    int cy = 0;
    we_ok = 1'b1;
    stalled = 1'b0;
    aq.delete();
    dq.delete();
    while (idx < n && cy < 200) begin
      @(negedge clk);
      cy++;
      if (idle > 0) begin
        in_valid = 1'b0;
        idle--;
      end else begin
        in_valid = (gap == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
        in_data = wbuf[idx];
        in_last = with_last && (idx == n - 1);
      end
      #1;
      if (imem_we !== (in_valid && in_ready)) we_ok = 1'b0;
      if (in_valid && in_ready) begin
        aq.push_back(imem_addr);
        dq.push_back(imem_wdata);
        idx++;
        if (gap == 1) idle = 3;
      end else if (in_valid) begin
        stalled = 1'b1;
        break;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    #1;
    acc = idx;
  endtask

  // From RUN: pulse cpu_stop and wait for the dump to begin.
  task automatic stop_to_dump(output bit ok);
    int cy = 0;
    @(negedge clk);
    cpu_stop = 1'b1;
    @(negedge clk);
    cpu_stop = 1'b0;
    #1;
    while (!out_valid && cy < 30) begin
      @(negedge clk);
      #1;
      cy++;
    end
    ok = out_valid;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({busy, done, err, cpu_rst, in_ready, out_valid, imem_we}
        !== 7'b1001100) begin
      errs++;
      $display("FAIL reset_flags: got %b want 1001100",
        {busy, done, err, cpu_rst, in_ready, out_valid, imem_we});
    end
    checks++;
    if (imem_addr !== 32'h0 || dmem_addr !== 32'h0) begin
      errs++;
      $display("FAIL reset_addr: got %h/%h want 0/0",
        imem_addr, dmem_addr);
    end
    // cpu_stop must be ignored while loading.
    @(negedge clk);
    cpu_stop = 1'b1;
    @(negedge clk);
    cpu_stop = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || cpu_rst !== 1'b1) begin
      errs++;
      $display("FAIL stop_in_load: rdy=%b rst=%b want 1/1",
        in_ready, cpu_rst);
    end
  endtask

  task automatic test_load(input int gap);
    int acc;
    bit we_ok;
    bit st;
    do_reset();
    wbuf[0] = 32'h20010005;
    wbuf[1] = 32'h20020003;
    wbuf[2] = 32'hFFFFFFFF;
    drive_load(3, 1'b1, gap, acc, we_ok, st);
    checks++;
    if (acc !== 3 || aq.size() !== 3 || !we_ok) begin
      errs++;
      $display("FAIL load_cnt gap%0d: acc=%0d wr=%0d we_ok=%b want 3/3/1",
        gap, acc, aq.size(), we_ok);
    end
    for (int i = 0; i < aq.size(); i++) begin
      checks++;
      if (aq[i] !== 32'(i * 4) || dq[i] !== wbuf[i]) begin
        errs++;
        $display("FAIL load_wr%0d gap%0d: got %h:%h want %h:%h",
          i, gap, aq[i], dq[i], 32'(i * 4), wbuf[i]);
      end
    end
    checks++;
    if (cpu_rst !== 1'b0 || in_ready !== 1'b0 || err !== 1'b0) begin
      errs++;
      $display("FAIL load_run gap%0d: rst=%b rdy=%b err=%b want 0/0/0",
        gap, cpu_rst, in_ready, err);
    end
  endtask

  task automatic test_overflow();
    int acc;
    bit we_ok;
    bit st;
    do_reset();
    for (int i = 0; i < 5; i++) wbuf[i] = $urandom;
    drive_load(5, 1'b0, 0, acc, we_ok, st);
    checks++;
    if (acc !== IMW || !st || !we_ok) begin
      errs++;
      $display("FAIL ovf_cnt: acc=%0d stall=%b we_ok=%b want %0d/1/1",
        acc, st, we_ok, IMW);
    end
    for (int i = 0; i < aq.size(); i++) begin
      checks++;
      if (aq[i] !== 32'(i * 4) || dq[i] !== wbuf[i]) begin
        errs++;
        $display("FAIL ovf_wr%0d: got %h:%h want %h:%h",
          i, aq[i], dq[i], 32'(i * 4), wbuf[i]);
      end
    end
    checks++;
    if (err !== 1'b1 || in_ready !== 1'b0 || cpu_rst !== 1'b0
        || busy !== 1'b1) begin
      errs++;
      $display("FAIL ovf_state: err=%b rdy=%b rst=%b busy=%b want 1/0/0/1",
        err, in_ready, cpu_rst, busy);
    end
  endtask

  task automatic test_drain();
    int acc;
    int n0 = 0;
    bit we_ok;
    bit st;
    do_reset();
    wbuf[0] = $urandom;
    wbuf[1] = $urandom;
    drive_load(2, 1'b1, 2, acc, we_ok, st);
    repeat ($urandom_range(0, 5)) @(negedge clk);
    @(negedge clk);
    cpu_stop = 1'b1;
    @(negedge clk);
    cpu_stop = 1'b0;
    #1;
    while (cpu_rst === 1'b0 && n0 < 20) begin
      n0++;
      @(negedge clk);
      #1;
    end
    checks++;
    if (n0 !== DRN) begin
      errs++;
      $display("FAIL drain_len: got %0d want %0d", n0, DRN);
    end
    checks++;
    if (out_valid !== 1'b1 || dmem_addr !== 32'h0 || err !== 1'b0) begin
      errs++;
      $display("FAIL dump_start: ov=%b addr=%h err=%b want 1/0/0",
        out_valid, dmem_addr, err);
    end
  endtask

  // mode 0: out_ready toggles 1010..., mode 1: random out_ready.
  task automatic test_dump(input int mode, input logic [31:0] k);
    int acc;
    int bt = 0;
    int cy = 0;
    bit we_ok;
    bit st;
    bit ok;
    bit tog = 1'b1;
    logic [31:0] exp;
    key = k;
    do_reset();
    for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
    drive_load(3, 1'b1, 0, acc, we_ok, st);
    stop_to_dump(ok);
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL dump_reach m%0d: out_valid=%b want 1", mode, out_valid);
    end
    while (bt < DMW && cy < 100) begin
      @(negedge clk);
      cy++;
      out_ready = (mode == 0) ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      #1;
      exp = 32'(bt * 4) ^ key;
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp
          || dmem_addr !== 32'(bt * 4)
          || out_last !== (bt == DMW - 1)) begin
        errs++;
        $display("FAIL beat%0d m%0d: ov=%b d=%h a=%h l=%b want 1/%h/%h/%b",
          bt, mode, out_valid, out_data, dmem_addr, out_last,
          exp, 32'(bt * 4), bt == DMW - 1);
      end
      if (out_ready) bt++;
    end
    checks++;
    if (bt !== DMW) begin
      errs++;
      $display("FAIL dump_beats m%0d: got %0d want %0d", mode, bt, DMW);
    end
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0
        || cpu_rst !== 1'b1) begin
      errs++;
      $display("FAIL done m%0d: d=%b b=%b ov=%b rst=%b want 1/0/0/1",
        mode, done, busy, out_valid, cpu_rst);
    end
    // DONE is terminal: new input must not be written.
    repeat (3) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_last = 1'b1;
      out_ready = 1'b1;
      #1;
      checks++;
      if (done !== 1'b1 || imem_we !== 1'b0 || in_ready !== 1'b0) begin
        errs++;
        $display("FAIL done_hold m%0d: d=%b we=%b rdy=%b want 1/0/0",
          mode, done, imem_we, in_ready);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_dump();
    int acc;
    bit we_ok;
    bit st;
    bit ok;
    key = $urandom;
    do_reset();
    wbuf[0] = $urandom;
    drive_load(1, 1'b1, 0, acc, we_ok, st);
    stop_to_dump(ok);
    repeat (2) begin
      @(negedge clk);
      out_ready = 1'b1;
    end
    @(negedge clk);
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dmem_addr !== 32'h8) begin
      errs++;
      $display("FAIL mid_dump_addr: got %h want 00000008", dmem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({busy, done, err, cpu_rst, in_ready, out_valid}
        !== 6'b100110) begin
      errs++;
      $display("FAIL mid_dump_rst: got %b want 100110",
        {busy, done, err, cpu_rst, in_ready, out_valid});
    end
    wbuf[0] = $urandom;
    drive_load(1, 1'b1, 0, acc, we_ok, st);
    stop_to_dump(ok);
    checks++;
    if (!ok || dmem_addr !== 32'h0 || out_data !== key) begin
      errs++;
      $display("FAIL redump: ov=%b a=%h d=%h want 1/0/%h",
        ok, dmem_addr, out_data, key);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int acc;
    int bt;
    int cy;
    bit we_ok;
    bit st;
    bit ok;
    logic [31:0] exp;
    for (int it = 0; it < 4; it++) begin
      n = (it == 0) ? IMW : int'($urandom_range(1, IMW));
      key = $urandom;
      do_reset();
      for (int i = 0; i < n; i++) wbuf[i] = $urandom;
      drive_load(n, 1'b1, 2, acc, we_ok, st);
      checks++;
      if (acc !== n || aq.size() !== n || !we_ok || err !== 1'b0) begin
        errs++;
        $display("FAIL b2b_load%0d: acc=%0d wr=%0d we=%b err=%b want %0d",
          it, acc, aq.size(), we_ok, err, n);
      end
      for (int i = 0; i < aq.size(); i++) begin
        checks++;
        if (aq[i] !== 32'(i * 4) || dq[i] !== wbuf[i]) begin
          errs++;
          $display("FAIL b2b_wr%0d_%0d: got %h:%h want %h:%h",
            it, i, aq[i], dq[i], 32'(i * 4), wbuf[i]);
        end
      end
      repeat ($urandom_range(0, 4)) @(negedge clk);
      stop_to_dump(ok);
      bt = 0;
      cy = 0;
      while (ok && bt < DMW && cy < 100) begin
        @(negedge clk);
        cy++;
        out_ready = 1'($urandom_range(0, 1));
        #1;
        exp = 32'(bt * 4) ^ key;
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp
            || out_last !== (bt == DMW - 1)) begin
          errs++;
          $display("FAIL b2b_beat%0d_%0d: ov=%b d=%h l=%b want 1/%h/%b",
            it, bt, out_valid, out_data, out_last, exp, bt == DMW - 1);
        end
        if (out_ready) bt++;
      end
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      checks++;
      if (bt !== DMW || done !== 1'b1 || busy !== 1'b0) begin
        errs++;
        $display("FAIL b2b_done%0d: beats=%0d d=%b b=%b want %0d/1/0",
          it, bt, done, busy, DMW);
      end
    end
  endtask

`ifdef LOADER_TIMEOUT_EN
  task automatic test_timeout();
    int acc;
    int c = 1;
    bit we_ok;
    bit st;
    do_reset();
    wbuf[0] = $urandom;
    wbuf[1] = $urandom;
    drive_load(2, 1'b1, 0, acc, we_ok, st);
    // c counts cycles since RUN entry (c=1 is the first RUN cycle).
    while (!out_valid && c < 60) begin
      if (c == TMO) begin
        checks++;
        if (err !== 1'b0) begin
          errs++;
          $display("FAIL tmo_early: err=%b want 0 at c=%0d", err, c);
        end
      end
      if (c == TMO + 1) begin
        checks++;
        if (err !== 1'b1 || cpu_rst !== 1'b0) begin
          errs++;
          $display("FAIL tmo_err: err=%b rst=%b want 1/0", err, cpu_rst);
        end
      end
      @(negedge clk);
      #1;
      c++;
    end
    checks++;
    if (c !== TMO + DRN + 1) begin
      errs++;
      $display("FAIL tmo_dump: dump at c=%0d want %0d", c, TMO + DRN + 1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load(0);
    test_load(1);
    test_overflow();
    test_drain();
    test_dump(0, 32'hA5A5A5A5);
    test_dump(1, $urandom);
    test_reset_mid_dump();
    test_back_to_back();
`ifdef LOADER_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
